ddr_rd_arbiter: RTL and testbench
=================================

DDR_RD_ARBITER -- requirements
Module: ddr_rd_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, DDR address width; DATA_W, 512, DDR data width; MAX_SKIP, 4, consecutive scan losses before scan is forced to win; TIMEOUT, 1023, cycles allowed in WAIT before abort.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 scan_req  input  1  hit-scan requester wants a read; held until scan_gnt.
REQ-005 scan_addr  input  ADDR_W  hit-scan read address; stable while scan_req high.
REQ-006 scan_gnt  output  1  one-cycle pulse: scan request accepted and issued.
REQ-007 scan_valid  output  1  one-cycle pulse: scan_data holds the returned line.
REQ-008 scan_data  output  DATA_W  registered read data for the scan requester.
REQ-009 exp_req, exp_addr, exp_gnt, exp_valid, exp_data  same directions/widths/meanings as the scan set, for the expand requester.
REQ-010 ddr_rd  output  1  one-cycle read strobe to the DDR port.
REQ-011 ddr_addr  output  ADDR_W  read address; held from issue until transaction end.
REQ-012 ddr_rd_valid  input  1  DDR data valid.
REQ-013 ddr_rd_done  input  1  DDR read complete; data accepted only when valid and done are both high.
REQ-014 ddr_rd_data  input  DATA_W  DDR read data.
REQ-015 busy  output  1  high in every state other than IDLE.
REQ-016 timeout_err  output  1  one-cycle pulse when a read is aborted on timeout.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, DELIVER; at most one DDR read outstanding.
REQ-018 IDLE: if scan_req or exp_req is high, latch winner owner and address, go to ISSUE; otherwise stay.
REQ-019 Arbitration: expand wins when both request, unless skip_cnt equals MAX_SKIP, in which case scan wins.
REQ-020 skip_cnt (3 bits) SHALL increment when scan_req is high and expand wins, clear when scan wins, saturate at MAX_SKIP, and hold in all other cycles.
REQ-021 ISSUE (exactly one cycle): ddr_rd=1, ddr_addr=latched address, winner's gnt=1; next state WAIT.
REQ-022 Latency: a request sampled in IDLE at cycle N SHALL produce ddr_rd and gnt in cycle N+1.
REQ-023 WAIT: on ddr_rd_valid & ddr_rd_done, register ddr_rd_data into the owner's data output and go to DELIVER; valid without done, or done without valid, SHALL be ignored.
REQ-024 DELIVER (one cycle): owner's valid=1; next state IDLE. A new request SHALL be arbitrated in the following IDLE cycle, giving a minimum issue-to-issue spacing of 4 cycles.
REQ-025 The non-owner's data output SHALL keep its previous value; scan_data and exp_data change only on delivery to their own port.
REQ-026 A wait counter (10 bits) SHALL clear on entry to WAIT and increment every WAIT cycle; when it reaches TIMEOUT, the block SHALL pulse timeout_err, return to IDLE, deliver no data, and assert no valid.
REQ-027 ddr_rd_valid or ddr_rd_done seen in IDLE, ISSUE or DELIVER SHALL be ignored.
REQ-028 A request deasserted before its gnt SHALL be treated as withdrawn and SHALL not be issued.
REQ-029 gnt and valid SHALL never be high for both requesters in the same cycle.

Reset
REQ-030 When rst is high: state=IDLE; ddr_rd, scan_gnt, exp_gnt, scan_valid, exp_valid, timeout_err, busy=0; ddr_addr, scan_data, exp_data=0; skip_cnt and wait counter=0.
REQ-031 Reset during WAIT SHALL abandon the outstanding read without any valid pulse; a late DDR response after reset SHALL be ignored per REQ-027.

Verification
REQ-032 Only scan_req with scan_addr=0x0000_0200 -> ddr_rd with ddr_addr=0x200 and scan_gnt in the next cycle; DDR returns 0xA5.. with valid&done -> scan_valid 1 cycle later, scan_data=0xA5.., exp_data unchanged.
REQ-033 scan_req and exp_req held continuously, DDR answering in 3 cycles -> grant order E,E,E,E,S,E,E,E,E,S; skip_cnt reaches 4 before each S.
REQ-034 Issue a read with no DDR response -> timeout_err pulses 1023 cycles after entry to WAIT, busy falls, no valid asserted, next request is issued normally.
REQ-035 In WAIT, pulse ddr_rd_valid alone, then ddr_rd_done alone -> no state change; both high together -> delivery.
REQ-036 Assert rst for 1 cycle mid-WAIT, then drive valid&done -> all outputs at reset values, no valid pulse, state IDLE.
REQ-037 Drop exp_req in the same cycle the FSM is in IDLE with scan_req low -> no ddr_rd, busy stays 0.

Source files
------------

// File: rtl/ddr_rd_arbiter.sv
// ddr_rd_arbiter: two-requester (hit-scan / expand) read arbiter in front of a
// single DDR read port. Keeps one read outstanding, favours expand but forces a
// scan win after MAX_SKIP consecutive scan losses, and aborts a read that gets
// no answer within TIMEOUT cycles.
module ddr_rd_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 512,
    parameter int MAX_SKIP = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_gnt,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    input  logic              exp_req,
    input  logic [ADDR_W-1:0] exp_addr,
    output logic              exp_gnt,
    output logic              exp_valid,
    output logic [DATA_W-1:0] exp_data,
    output logic              ddr_rd,
    output logic [ADDR_W-1:0] ddr_addr,
    input  logic              ddr_rd_valid,
    input  logic              ddr_rd_done,
    input  logic [DATA_W-1:0] ddr_rd_data,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [2:0] MAX_SKIP_C = 3'(MAX_SKIP);
    localparam logic [9:0] TIMEOUT_C  = 10'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t              state_q, state_d;
    logic                owner_scan_q, owner_scan_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          skip_cnt_q, skip_cnt_d;
    logic [9:0]          wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]   scan_data_q, scan_data_d;
    logic [DATA_W-1:0]   exp_data_q, exp_data_d;

    logic                any_req;
    logic                scan_wins;
    logic                rd_accept;
    logic                wait_expired;

    assign any_req      = scan_req | exp_req;
    // Expand has priority unless scan has already lost MAX_SKIP times in a row.
    assign scan_wins    = scan_req & (~exp_req | (skip_cnt_q == MAX_SKIP_C));
    assign rd_accept    = ddr_rd_valid & ddr_rd_done;
    assign wait_expired = (wait_cnt_q == TIMEOUT_C);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; timeout takes precedence over a same-cycle response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (any_req) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT: begin
                if (wait_expired) begin
                    state_d = S_IDLE;
                end else if (rd_accept) begin
                    state_d = S_DELIVER;
                end
            end
            S_DELIVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state and the latched owner.
    always_comb begin
        busy        = (state_q != S_IDLE);
        ddr_rd      = (state_q == S_ISSUE);
        scan_gnt    = (state_q == S_ISSUE) &  owner_scan_q;
        exp_gnt     = (state_q == S_ISSUE) & ~owner_scan_q;
        scan_valid  = (state_q == S_DELIVER) &  owner_scan_q;
        exp_valid   = (state_q == S_DELIVER) & ~owner_scan_q;
        timeout_err = (state_q == S_WAIT) & wait_expired;
    end

    assign ddr_addr  = addr_q;
    assign scan_data = scan_data_q;
    assign exp_data  = exp_data_q;

    // Next values for owner, address, fairness counter, wait counter and data.
    always_comb begin
        owner_scan_d = owner_scan_q;
        addr_d       = addr_q;
        skip_cnt_d   = skip_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        scan_data_d  = scan_data_q;
        exp_data_d   = exp_data_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    owner_scan_d = scan_wins;
                    addr_d       = scan_wins ? scan_addr : exp_addr;
                    if (scan_wins) begin
                        skip_cnt_d = 3'd0;
                    end else if (scan_req && (skip_cnt_q < MAX_SKIP_C)) begin
                        skip_cnt_d = skip_cnt_q + 3'd1;
                    end
                end
            end
            S_ISSUE: wait_cnt_d = 10'd0;
            S_WAIT: begin
                if (!wait_expired) begin
                    wait_cnt_d = wait_cnt_q + 10'd1;
                    if (rd_accept) begin
                        if (owner_scan_q) begin
                            scan_data_d = ddr_rd_data;
                        end else begin
                            exp_data_d = ddr_rd_data;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and counter registers; reset clears everything, including data.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_scan_q <= 1'b0;
            addr_q       <= '0;
            skip_cnt_q   <= 3'd0;
            wait_cnt_q   <= 10'd0;
            scan_data_q  <= '0;
            exp_data_q   <= '0;
        end else begin
            owner_scan_q <= owner_scan_d;
            addr_q       <= addr_d;
            skip_cnt_q   <= skip_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            scan_data_q  <= scan_data_d;
            exp_data_q   <= exp_data_d;
        end
    end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb_ddr_rd_arbiter: directed and randomized transactions against a
// transaction-level reference model of the arbiter.
module tb_ddr_rd_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 512;
    localparam int MAX_SKIP = 4;
    localparam int TIMEOUT  = 1023;

    logic              clk = 1'b0;
    logic              rst;
    logic              scan_req, exp_req;
    logic [ADDR_W-1:0] scan_addr, exp_addr;
    logic              scan_gnt, scan_valid, exp_gnt, exp_valid;
    logic [DATA_W-1:0] scan_data, exp_data;
    logic              ddr_rd;
    logic [ADDR_W-1:0] ddr_addr;
    logic              ddr_rd_valid, ddr_rd_done;
    logic [DATA_W-1:0] ddr_rd_data;
    logic              busy, timeout_err;

    always #5 clk = ~clk;

    ddr_rd_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_SKIP(MAX_SKIP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_gnt(scan_gnt),
        .scan_valid(scan_valid), .scan_data(scan_data),
        .exp_req(exp_req), .exp_addr(exp_addr), .exp_gnt(exp_gnt),
        .exp_valid(exp_valid), .exp_data(exp_data),
        .ddr_rd(ddr_rd), .ddr_addr(ddr_addr),
        .ddr_rd_valid(ddr_rd_valid), .ddr_rd_done(ddr_rd_done),
        .ddr_rd_data(ddr_rd_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: scan losses since last scan win, and last line delivered per port.
    int                m_skip = 0;
    logic [DATA_W-1:0] m_scan_data = '0;
    logic [DATA_W-1:0] m_exp_data  = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp_v);
        end
    endtask

    task automatic chka(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chkd(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // Predict the winner of an arbitration and advance the fairness model.
    function automatic logic model_arbitrate(input logic s, input logic e);
        logic ws;
        ws = s && (!e || m_skip == MAX_SKIP);
        if (ws) m_skip = 0;
        else if (s && m_skip < MAX_SKIP) m_skip = m_skip + 1;
        return ws;
    endfunction

    // One full read starting from an IDLE cycle; got_scan returns the observed scan_gnt.
    task automatic run_txn(input logic s, input logic e, input logic [ADDR_W-1:0] sa,
                           input logic [ADDR_W-1:0] ea, input int delay,
                           input logic [DATA_W-1:0] data, output logic got_scan);
        logic              ws;
        logic [ADDR_W-1:0] wa;
        chk1("idle_busy", busy, 1'b0);
        scan_req = s; exp_req = e; scan_addr = sa; exp_addr = ea;
        ws = model_arbitrate(s, e);
        wa = ws ? sa : ea;
        step();
        got_scan = scan_gnt;
        chk1("issue_ddr_rd", ddr_rd, 1'b1);
        chka("issue_addr", ddr_addr, wa);
        chk1("issue_scan_gnt", scan_gnt, ws);
        chk1("issue_exp_gnt", exp_gnt, !ws);
        chk1("issue_busy", busy, 1'b1);
        chk1("issue_valid", scan_valid | exp_valid, 1'b0);
        ddr_rd_valid = 1'b1; ddr_rd_done = 1'b1; ddr_rd_data = rand_data();
        scan_req = 1'($urandom_range(0, 1)); exp_req = 1'($urandom_range(0, 1));
        step();
        for (int i = 0; i <= delay; i++) begin
            chk1("wait_ddr_rd", ddr_rd, 1'b0);
            chk1("wait_gnt", scan_gnt | exp_gnt, 1'b0);
            chk1("wait_valid", scan_valid | exp_valid, 1'b0);
            chk1("wait_busy", busy, 1'b1);
            chka("wait_addr_hold", ddr_addr, wa);
            chkd("wait_scan_data", scan_data, m_scan_data);
            chkd("wait_exp_data", exp_data, m_exp_data);
            if (i < delay) begin
                ddr_rd_valid = (i % 2 == 0);
                ddr_rd_done  = (i % 2 != 0);
                ddr_rd_data  = rand_data();
            end else begin
                ddr_rd_valid = 1'b1; ddr_rd_done = 1'b1; ddr_rd_data = data;
            end
            step();
        end
        if (ws) m_scan_data = data;
        else    m_exp_data  = data;
        chk1("dlv_scan_valid", scan_valid, ws);
        chk1("dlv_exp_valid", exp_valid, !ws);
        chkd("dlv_scan_data", scan_data, m_scan_data);
        chkd("dlv_exp_data", exp_data, m_exp_data);
        chk1("dlv_busy", busy, 1'b1);
        chk1("dlv_gnt", scan_gnt | exp_gnt | ddr_rd, 1'b0);
        ddr_rd_valid = 1'b1; ddr_rd_done = 1'b1; ddr_rd_data = rand_data();
        scan_req = 1'($urandom_range(0, 1)); exp_req = 1'b1;
        step();
        ddr_rd_valid = 1'b0; ddr_rd_done = 1'b0;
        chk1("end_busy", busy, 1'b0);
        chk1("end_valid", scan_valid | exp_valid, 1'b0);
        chkd("end_scan_data", scan_data, m_scan_data);
        chkd("end_exp_data", exp_data, m_exp_data);
    endtask

    initial begin
        logic              got;
        logic              s, e, ws;
        logic [ADDR_W-1:0] ea;
        int                bad;
        bit                order_tbl [10];

        order_tbl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        scan_req = 1'b0; exp_req = 1'b0; scan_addr = '0; exp_addr = '0;
        ddr_rd_valid = 1'b0; ddr_rd_done = 1'b0; ddr_rd_data = '0;
        step();
        step();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ddr_rd", ddr_rd, 1'b0);
        chk1("rst_gnt", scan_gnt | exp_gnt, 1'b0);
        chk1("rst_valid", scan_valid | exp_valid, 1'b0);
        chk1("rst_timeout", timeout_err, 1'b0);
        chka("rst_addr", ddr_addr, '0);
        chkd("rst_scan_data", scan_data, '0);
        chkd("rst_exp_data", exp_data, '0);
        rst = 1'b0;
        step();

        // Scan-only read of 0x200 returning an A5 pattern.
        run_txn(1'b1, 1'b0, 32'h0000_0200, $urandom(), 0, {8{64'hA5A5_A5A5_A5A5_A5A5}}, got);

        // Partial handshakes in WAIT must be ignored until both arrive together.
        run_txn(1'b0, 1'b1, $urandom(), $urandom(), 4, rand_data(), got);

        // Randomized mix of requesters, addresses, data and response delays.
        for (int n = 0; n < 30; n++) begin
            s = 1'($urandom_range(0, 1));
            e = 1'($urandom_range(0, 1));
            if (!s && !e) begin
                scan_req = 1'b0; exp_req = 1'b0;
                step();
                chk1("quiet_ddr_rd", ddr_rd, 1'b0);
                chk1("quiet_busy", busy, 1'b0);
            end else begin
                run_txn(s, e, $urandom(), $urandom(), int'($urandom_range(0, 6)), rand_data(), got);
            end
        end

        // Reset in the middle of WAIT abandons the read; a late response is ignored.
        scan_req = 1'b1; exp_req = 1'b0; scan_addr = $urandom();
        ws = model_arbitrate(1'b1, 1'b0);
        step();
        chk1("rstw_issue_gnt", scan_gnt, ws);
        scan_req = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        m_skip = 0; m_scan_data = '0; m_exp_data = '0;
        chk1("rstw_busy", busy, 1'b0);
        chk1("rstw_valid", scan_valid | exp_valid, 1'b0);
        chka("rstw_addr", ddr_addr, '0);
        chkd("rstw_scan_data", scan_data, '0);
        chkd("rstw_exp_data", exp_data, '0);
        rst = 1'b0;
        ddr_rd_valid = 1'b1; ddr_rd_done = 1'b1; ddr_rd_data = rand_data();
        step();
        chk1("late_valid", scan_valid | exp_valid, 1'b0);
        chk1("late_busy", busy, 1'b0);
        chkd("late_scan_data", scan_data, '0);
        chkd("late_exp_data", exp_data, '0);
        ddr_rd_valid = 1'b0; ddr_rd_done = 1'b0;
        step();
        chk1("late_busy2", busy, 1'b0);

        // Both requesters held: expand four times, then scan, repeating.
        for (int n = 0; n < 10; n++) begin
            run_txn(1'b1, 1'b1, $urandom(), $urandom(), 2, rand_data(), got);
            chk1($sformatf("order_%0d", n), got, order_tbl[n]);
        end

        // No response at all: abort after TIMEOUT cycles in WAIT.
        ea = $urandom();
        scan_req = 1'b0; exp_req = 1'b1; exp_addr = ea;
        ws = model_arbitrate(1'b0, 1'b1);
        step();
        chk1("to_issue_gnt", exp_gnt, !ws);
        chka("to_issue_addr", ddr_addr, ea);
        exp_req = 1'b0;
        step();
        bad = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            if (timeout_err !== 1'b0 || scan_valid !== 1'b0 || exp_valid !== 1'b0 || busy !== 1'b1) bad++;
            step();
        end
        chki("to_early_events", bad, 0);
        chk1("to_pulse", timeout_err, 1'b1);
        chk1("to_pulse_valid", scan_valid | exp_valid, 1'b0);
        step();
        chk1("to_after_busy", busy, 1'b0);
        chk1("to_after_pulse", timeout_err, 1'b0);
        chk1("to_after_valid", scan_valid | exp_valid, 1'b0);
        chkd("to_scan_data", scan_data, m_scan_data);
        chkd("to_exp_data", exp_data, m_exp_data);
        run_txn(1'b1, 1'b0, $urandom(), $urandom(), 1, rand_data(), got);

        // exp_req raised during a read but dropped by the IDLE cycle is withdrawn.
        scan_req = 1'b0; exp_req = 1'b0;
        step();
        chk1("wd_ddr_rd", ddr_rd, 1'b0);
        chk1("wd_gnt", exp_gnt, 1'b0);
        chk1("wd_busy", busy, 1'b0);
        step();
        chk1("wd_busy2", busy, 1'b0);

        for (int n = 0; n < 6; n++) begin
            run_txn(1'($urandom_range(0, 1)), 1'b1, $urandom(), $urandom(),
                    int'($urandom_range(0, 3)), rand_data(), got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
